dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port `datamem` block (8-bit address, 16-bit data, write on rising `clk` when `en`=1, asynchronous read) between NREQ requesters, e.g. the DSP core and the sample-loader DMA.
- Grants at most one access per cycle using round-robin priority.
- Drives the memory port and returns registered read data tagged to the winning requester.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 8, address width (matches `datamem`).
- DW, 16, data width (matches `datamem`).
- LOCK_MAX, 8, maximum consecutive locked cycles before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester access request; held until granted.
- we  in  NREQ  per-requester write enable (1=write, 0=read); valid while req=1.
- addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- lock  in  NREQ  per-requester lock request; ignored unless DMEM_ARB_LOCK_EN.
- gnt  out  NREQ  one-hot grant; the access completes in any cycle where gnt[i]=1.
- rdata  out  DW  registered read data.
- rvalid  out  NREQ  one-hot pulse marking rdata as belonging to requester i.
- mem_en  out  1  to `datamem` `en`.
- mem_addr  out  AW  to `datamem` `addr`.
- mem_wdata  out  DW  to `datamem` `in`.
- mem_rdata  in  DW  from `datamem` `out`.

Behaviour:
- Reset (asynchronous, any time):
  - ptr=0, rdata=0, rvalid=0, locked=0, lock_cnt=0.
  - gnt=0 and mem_en=0 while reset=1, so no memory write happens during reset.
  - An access in flight when reset asserts is dropped; the requester re-requests after reset.
- Arbitration (combinational, same cycle):
  - Scan req starting at index ptr and wrapping modulo NREQ; the first set bit wins.
  - gnt=onehot(winner), or gnt=0 if req=0.
- Pointer update at the edge: if any grant, ptr <= (winner+1) mod NREQ; otherwise ptr holds.
- Memory port, driven from the winner's fields:
  - mem_addr = addr[winner], mem_wdata = wdata[winner].
  - mem_en = |gnt & we[winner].
  - With no grant: mem_addr=0, mem_wdata=0, mem_en=0.
- Write latency: memory is updated at the edge ending the grant cycle.
- Read:
  - If the grant cycle is a read, rdata <= mem_rdata at that edge and rvalid <= gnt.
  - Otherwise rvalid <= 0 and rdata holds its last value.
  - Read latency is therefore 1 cycle after gnt.
- Throughput:
  - One access per cycle.
  - A requester holding req=1 after gnt is issuing a new access, with new fields allowed in the following cycle.
  - A lone requester is granted every cycle.
  - Two continuous requesters alternate 0,1,0,1.
- Same-address write-then-read by another requester in the next cycle returns the new data (the write is visible through the async read).
- No requester waits more than NREQ-1 grants (round-robin guarantee, no lock).

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro, a lock FSM (UNLOCKED/LOCKED, owner register, lock_cnt) provides atomic read-modify-write:
  - Lock entry: gnt[i]&lock[i] while UNLOCKED -> LOCKED, owner=i, lock_cnt=1.
  - While LOCKED, only the owner is eligible for grant; ptr does not advance.
  - Each LOCKED cycle increments lock_cnt.
  - Release to UNLOCKED at the edge when any of these holds:
    - owner is granted with lock=0;
    - owner has req=0;
    - lock_cnt reaches LOCK_MAX.
  - On release, ptr <= (owner+1) mod NREQ.
  - Forced release does not abort the current-cycle grant.
- Without the macro:
  - The lock port is ignored and no lock state is synthesized.
  - Arbitration is pure round-robin.

Decomposition:
- Shared package dmem_arb_pkg: DMEM_AW=8, DMEM_DW=16, lock state enum {UNLOCKED, LOCKED}, helper function for modulo-NREQ increment.
- One sub-module, dmem_rr_pick: combinational round-robin picker (inputs req and ptr; outputs one-hot gnt and winner index).

Test Plan:
- Reset mid-write: req[0]=1, we=1, addr0=8'h15, reset asserted in the same cycle -> gnt=0, mem_en=0, mem[15] unchanged, all outputs at reset values.
- Single write then read: req0 writes 16'h1234 to 8'h15, then reads 8'h15 -> rvalid[0]=1 one cycle after gnt, rdata=16'h1234.
- Contention: req0 and req1 both held high for 6 cycles after reset -> gnt sequence 01,10,01,10,01,10 (one-hot, bit0 first).
- Cross-requester coherence: req0 writes 16'habcd to 8'h20, next cycle req1 reads 8'h20 -> rvalid[1]=1 with rdata=16'habcd.
- Idle/ptr hold: after gnt to 1, no req for 3 cycles, then both request -> gnt[0] first.
- DMEM_ARB_LOCK_EN: req0 with lock0=1 for 12 cycles while req1=1 -> gnt stays 01 for 8 cycles, forced release, next grant to requester 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared definitions for the datamem arbiter: the memory geometry
//            that matches the datamem block, the lock state encoding and a
//            modulo-N increment helper used by the round-robin pointer.
// Contents : DMEM_AW, DMEM_DW, lock_state_t, rr_inc()
// Options  : lock_state_t is only used when DMEM_ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Next index after idx, wrapping at n.
  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rr_pick
// Purpose  : Combinational round-robin picker. Scans req starting at ptr,
//            wrapping modulo NREQ; the first set bit wins.
// Ports    : req    in  NREQ  eligible requests
//            ptr    in  PW    index with highest priority this cycle
//            gnt    out NREQ  one-hot grant (0 when req=0)
//            winner out PW    index of the granted requester (0 when none)
//            any    out 1     at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module dmem_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            any
);

  logic [PW-1:0] idx;

  // Walk the scan order backwards so the last hit assigned is the first one
  // in priority order; this avoids a loop break.
  always_comb begin
    gnt    = '0;
    winner = '0;
    idx    = '0;
    any    = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
    if (any) begin
      gnt = NREQ'(1) << winner;
    end
  end

endmodule : dmem_rr_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port datamem (async read, write on rising clk
//            when en=1) between NREQ requesters with round-robin priority.
//            At most one access per cycle; read data is registered and
//            tagged to the requester that issued it.
// Ports    : clk, reset (async, active-high)
//            req/we/lock [NREQ], addr [NREQ*AW], wdata [NREQ*DW]  requesters
//            gnt [NREQ] one-hot grant, rdata [DW], rvalid [NREQ]   responses
//            mem_en, mem_addr, mem_wdata -> datamem; mem_rdata <- datamem
// Options  : DMEM_ARB_LOCK_EN - enables the lock FSM for atomic
//            read-modify-write; without it lock is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic             mem_en,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   winner;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_gnt;
  logic            any_pick;
  logic            any_gnt;
  logic            is_read;

`ifdef DMEM_ARB_LOCK_EN
  localparam int            CW       = $clog2(LOCK_MAX + 1);
  // Counter value seen in the final permitted locked cycle: the entry cycle
  // plus LOCK_MAX-1 locked cycles gives LOCK_MAX consecutive owner grants.
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  lock_state_t     lock_state;
  lock_state_t     lock_state_nxt;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   owner_nxt;
  logic [CW-1:0]   lock_cnt;
  logic [CW-1:0]   lock_cnt_nxt;
  logic [NREQ-1:0] owner_mask;

  assign owner_mask = NREQ'(1) << owner;
  // While locked only the owner may be granted.
  assign elig = (lock_state == LOCKED) ? (req & owner_mask) : req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_state <= UNLOCKED;
      owner      <= '0;
      lock_cnt   <= '0;
    end else begin
      lock_state <= lock_state_nxt;
      owner      <= owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  always_comb begin
    lock_state_nxt = lock_state;
    owner_nxt      = owner;
    lock_cnt_nxt   = lock_cnt;
    ptr_nxt        = ptr;
    case (lock_state)
      UNLOCKED: begin
        if (any_gnt) begin
          ptr_nxt = PW'(rr_inc(int'(winner), NREQ));
          if (lock[winner]) begin
            lock_state_nxt = LOCKED;
            owner_nxt      = winner;
            lock_cnt_nxt   = CW'(1);
          end
        end
      end
      LOCKED: begin
        // The owner is granted whenever it requests, so "granted with lock=0"
        // reduces to lock[owner]=0. A forced release still lets this cycle's
        // grant complete; only the next cycle reopens arbitration.
        if (!req[owner] || !lock[owner] || (lock_cnt >= CNT_LAST)) begin
          lock_state_nxt = UNLOCKED;
          lock_cnt_nxt   = '0;
          ptr_nxt        = PW'(rr_inc(int'(owner), NREQ));
        end else begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end
      end
      default: begin
        lock_state_nxt = UNLOCKED;
      end
    endcase
  end
`else
  logic lock_unused;

  assign lock_unused = ^lock;
  assign elig        = req;

  always_comb begin
    ptr_nxt = ptr;
    if (any_gnt) begin
      ptr_nxt = PW'(rr_inc(int'(winner), NREQ));
    end
  end
`endif

  dmem_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (elig),
    .ptr    (ptr),
    .gnt    (pick_gnt),
    .winner (winner),
    .any    (any_pick)
  );

  // Grants are suppressed while reset is high so no write can reach memory.
  assign any_gnt   = any_pick & ~reset;
  assign gnt       = any_gnt ? pick_gnt : '0;
  assign mem_en    = any_gnt & we[winner];
  assign is_read   = any_gnt & ~we[winner];
  assign mem_addr  = any_gnt ? addr[winner*AW +: AW]  : '0;
  assign mem_wdata = any_gnt ? wdata[winner*DW +: DW] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // datamem reads asynchronously, so the read value is captured at the edge
  // that ends the grant cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= '0;
    end else if (is_read) begin
      rdata  <= mem_rdata;
      rvalid <= pick_gnt;
    end else begin
      rvalid <= '0;
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (NREQ=2) with a
//            behavioural datamem (async read, write on rising clk when en).
// Options  : DMEM_ARB_LOCK_EN - adds the forced-release lock scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 16;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;
  logic             mem_en;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  logic [DW-1:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .DW       (DW),
    .LOCK_MAX (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .lock      (lock),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
    reset = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    lock  = '0;

    // Write request present while reset is held.
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h15; wdata[15:0] = 16'hDEAD;
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    tick();
    tick();
    check("rst_mem_keep", 32'(mem[8'h15]), 32'hA515);

    // Release reset mid-cycle, then reassert before the write edge.
    reset = 1'b0;
    #2;
    check("prerst_gnt", 32'(gnt), 32'h1);
    check("prerst_mem_en", 32'(mem_en), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_mem_en", 32'(mem_en), 32'h0);
    tick();
    check("midrst_mem_keep", 32'(mem[8'h15]), 32'hA515);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    reset = 1'b0;
    req   = '0;
    tick();

    // Single write then read by requester 0.
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h15; wdata[15:0] = 16'h1234;
    #3;
    check("wr_gnt", 32'(gnt), 32'h1);
    check("wr_mem_en", 32'(mem_en), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h15);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    check("wr_no_rvalid", 32'(rvalid), 32'h0);
    check("wr_mem", 32'(mem[8'h15]), 32'h1234);
    we = 2'b00;
    #3;
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_mem_en", 32'(mem_en), 32'h0);
    tick();
    check("rd_rvalid", 32'(rvalid), 32'h1);
    check("rd_rdata", 32'(rdata), 32'h1234);
    req = '0;
    #3;
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_mem_addr", 32'(mem_addr), 32'h0);
    tick();
    check("idle_rvalid", 32'(rvalid), 32'h0);
    check("idle_rdata_hold", 32'(rdata), 32'h1234);

    // Contention right after reset: alternation starting with requester 0.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 2'b11; we = 2'b00; addr[7:0] = 8'h15; addr[15:8] = 8'h30;
    exp_g = 2'b01;
    for (int i = 0; i < 6; i++) begin
      #2;
      check($sformatf("cont_gnt%0d", i), 32'(gnt), 32'(exp_g));
      tick();
      check($sformatf("cont_rvalid%0d", i), 32'(rvalid), 32'(exp_g));
      check($sformatf("cont_rdata%0d", i), 32'(rdata),
            (exp_g == 2'b01) ? 32'h1234 : 32'hA530);
      exp_g = ~exp_g;
    end

    // Idle with pointer held, then both request: requester 0 first.
    req = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("hold_gnt%0d", i), 32'(gnt), 32'h0);
      tick();
    end
    req = 2'b11;
    #2;
    check("hold_first", 32'(gnt), 32'h1);
    tick();

    // Cross-requester coherence: 0 writes, 1 reads the same address.
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h20; wdata[15:0] = 16'hABCD;
    #2;
    check("coh_wr_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b10; we = 2'b00; addr[15:8] = 8'h20;
    #2;
    check("coh_rd_gnt", 32'(gnt), 32'h2);
    tick();
    check("coh_rvalid", 32'(rvalid), 32'h2);
    check("coh_rdata", 32'(rdata), 32'hABCD);
    req = '0;
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Requester 0 holds the lock; forced release after 8 grants.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 2'b11; we = 2'b00; lock = 2'b01;
    for (int i = 0; i < 9; i++) begin
      #2;
      check($sformatf("lock_gnt%0d", i), 32'(gnt), (i < 8) ? 32'h1 : 32'h2);
      tick();
    end
    req  = '0;
    lock = '0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
